// File: rtl/fft_output_reorder.sv
// Output reorder buffer for the 32-point SDF FFT: accepts frames in bit-reversed
// order and re-emits them in natural order through two ping-pong banks.
module fft_output_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic          out_last
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

  logic [2*DW-1:0]  bank_q [2][N];
  logic [2*DW-1:0]  bank_d [2][N];
  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [2*DW-1:0]  rd_word_s;

  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign wr_en_s   = in_valid & in_ready;
  assign rd_en_s   = out_valid & out_ready;
  assign rd_word_s = bank_q[rb_q][rcnt_q];
  assign out_r     = out_valid ? rd_word_s[2*DW-1:DW] : {DW{1'b0}};
  assign out_i     = out_valid ? rd_word_s[DW-1:0]    : {DW{1'b0}};
  assign out_last  = out_valid & (rcnt_q == LAST);

  // Next-state for counters, bank pointers and full flags.
  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    full_d = full_q;
    // A write needs a free bank and a read needs a full one, so when both
    // complete in the same cycle they always touch different banks.
    if (wr_en_s) begin
      if (wcnt_q == LAST) begin
        wcnt_d       = {LOG2N{1'b0}};
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end else begin
        wcnt_d = wcnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
      end
    end else begin
      wcnt_d = wcnt_q;
    end
    if (rd_en_s) begin
      if (rcnt_q == LAST) begin
        rcnt_d       = {LOG2N{1'b0}};
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        rcnt_d = rcnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
      end
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // Next-state for bank storage: scatter the incoming sample to its natural slot.
  always_comb begin
    bank_d = bank_q;
    if (wr_en_s) begin
      bank_d[wb_q][bitrev(wcnt_q)] = {in_r, in_i};
    end else begin
      bank_d = bank_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= {LOG2N{1'b0}};
      rcnt_q <= {LOG2N{1'b0}};
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      full_q <= 2'b00;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      full_q <= full_d;
    end
  end

  // Bank storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder against a frame-level queue model.
module tb_fft_output_reorder;

  localparam int N  = 32;
  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          out_last;

  fft_output_reorder #(.N(N), .LOG2N(5), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: partial input frame plus queue of pending natural-order samples.
  logic [DW-1:0] part_r [N];
  logic [DW-1:0] part_i [N];
  logic [DW-1:0] pend_r [$];
  logic [DW-1:0] pend_i [$];
  int widx, ridx, nfr, fin;
  logic [DW-1:0] cur_r, cur_i;
  int kind;
  int phase;

  function automatic int bitrev5(input int x);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((x >> b) & 1) r += 1 << (4 - b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen();
    case (kind)
      0: begin cur_r = DW'(bitrev5(widx)); cur_i = DW'(-bitrev5(widx)); end
      1: begin cur_r = DW'(100 * fin + bitrev5(widx)); cur_i = DW'($urandom); end
      2: begin
        cur_r = widx[0] ? 17'h0FFFF : 17'h10000;
        cur_i = widx[0] ? 17'h10000 : 17'h0FFFF;
      end
      default: begin cur_r = DW'($urandom); cur_i = DW'($urandom); end
    endcase
  endtask

  task automatic model_clear();
    pend_r.delete(); pend_i.delete();
    widx = 0; ridx = 0; nfr = 0; fin = 0;
  endtask

  // vmode: 0 always valid, 1 random; rmode: 0 ready, 1 stalled, 2 toggle, 3 random
  task automatic run(input int cycles, input int nsamp, input int vmode, input int rmode);
    int acc = 0;
    logic iv, ordy, ev, er;
    gen();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      ev = (nfr > 0);
      er = (nfr < 2);
      iv = (acc < nsamp) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
      case (rmode)
        0: ordy = 1'b1;
        1: ordy = 1'b0;
        2: ordy = (c % 2 == 0);
        default: ordy = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = iv; in_r = cur_r; in_i = cur_i; out_ready = ordy;
      #1;
      chk($sformatf("p%0d in_ready", phase), DW'(in_ready), DW'(er));
      chk($sformatf("p%0d out_valid", phase), DW'(out_valid), DW'(ev));
      chk($sformatf("p%0d out_last", phase), DW'(out_last), DW'(ev && ridx == N - 1));
      chk($sformatf("p%0d out_r", phase), out_r, ev ? pend_r[0] : '0);
      chk($sformatf("p%0d out_i", phase), out_i, ev ? pend_i[0] : '0);
      if (ev && ordy) begin
        void'(pend_r.pop_front()); void'(pend_i.pop_front());
        ridx++;
        if (ridx == N) begin ridx = 0; nfr--; end
      end
      if (iv && er) begin
        part_r[widx] = cur_r; part_i[widx] = cur_i;
        acc++; widx++;
        if (widx == N) begin
          for (int k = 0; k < N; k++) begin
            pend_r.push_back(part_r[bitrev5(k)]);
            pend_i.push_back(part_i[bitrev5(k)]);
          end
          widx = 0; nfr++; fin++;
        end
        gen();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_r = '0; in_i = '0;
    model_clear();
    kind = 0; phase = 0;
    do_reset();
    // single frame
    phase = 1; kind = 0; run(70, 32, 0, 0);
    // continuous stream of four tagged frames
    phase = 2; kind = 1; fin = 0; run(170, 128, 0, 0);
    // backpressure: fill both banks, then release
    phase = 3; kind = 3; run(80, 96, 0, 1);
    run(140, 32, 0, 0);
    // output stall mid-frame
    phase = 4; kind = 0; run(100, 32, 0, 2);
    // sign extremes with random handshakes
    phase = 5; kind = 2; run(150, 32, 1, 3);
    run(60, 0, 0, 0);
    // reset mid-operation: frame 0 half drained, 20 samples of frame 1 in
    phase = 6; kind = 3; run(32, 32, 0, 1);
    run(20, 20, 0, 0);
    do_reset();
    run(70, 32, 0, 0);
    // random mix
    phase = 7; kind = 3; run(500, 256, 1, 3);
    run(200, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
